// File: rtl/fifo_arb_ctrl.sv
// Round-robin two-producer write arbiter and single-consumer read sequencer for an external sp_fifo.
// Optional FIFO_ARB_STATS_EN adds saturating per-producer grant counters.
module fifo_arb_ctrl #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_valid,
    input  logic [7:0]    p0_data,
    output logic          p0_ready,
    input  logic          p1_valid,
    input  logic [7:0]    p1_data,
    output logic          p1_ready,
    input  logic          c_req,
    output logic          c_ack,
    output logic          c_valid,
    output logic [7:0]    c_data,
    output logic          fifo_wr_en,
    output logic [7:0]    fifo_din,
    output logic          fifo_rd_en,
    input  logic [7:0]    fifo_dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1,
`endif
    output logic          underflow_err
);

    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;  // 1: producer 1 was granted most recently
    logic          fifo_wr_en_q, fifo_wr_en_d;
    logic [7:0]    fifo_din_q, fifo_din_d;
    logic          fifo_rd_en_q, fifo_rd_en_d;
    logic          c_valid_q, c_valid_d;
    logic [7:0]    c_data_hold_q, c_data_hold_d;
    logic          underflow_q, underflow_d;
    logic          full_w, empty_w, gnt0, gnt1, ack, wr_xfer;

    always_comb begin
        full_w  = (count_q == CW'(DEPTH));
        empty_w = (count_q == '0);
        gnt0    = rst_n & p0_valid & ~full_w & (~p1_valid | last_q);
        gnt1    = rst_n & p1_valid & ~full_w & (~p0_valid | ~last_q);
        wr_xfer = gnt0 | gnt1;
        ack     = rst_n & c_req & ~empty_w;

        last_d        = last_q;
        fifo_wr_en_d  = wr_xfer;
        fifo_din_d    = fifo_din_q;
        fifo_rd_en_d  = ack;
        c_valid_d     = fifo_rd_en_q;
        c_data_hold_d = c_data_hold_q;
        underflow_d   = c_req & empty_w;
        count_d       = count_q;

        if (gnt0) begin
            last_d     = 1'b0;
            fifo_din_d = p0_data;
        end else if (gnt1) begin
            last_d     = 1'b1;
            fifo_din_d = p1_data;
        end
        if (c_valid_q) begin
            c_data_hold_d = fifo_dout;
        end
        case ({wr_xfer, ack})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            last_q        <= 1'b1;
            fifo_wr_en_q  <= 1'b0;
            fifo_din_q    <= '0;
            fifo_rd_en_q  <= 1'b0;
            c_valid_q     <= 1'b0;
            c_data_hold_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            count_q       <= count_d;
            last_q        <= last_d;
            fifo_wr_en_q  <= fifo_wr_en_d;
            fifo_din_q    <= fifo_din_d;
            fifo_rd_en_q  <= fifo_rd_en_d;
            c_valid_q     <= c_valid_d;
            c_data_hold_q <= c_data_hold_d;
            underflow_q   <= underflow_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (gnt0 && grant_cnt0_q != '1) grant_cnt0_d = grant_cnt0_q + 16'd1;
        if (gnt1 && grant_cnt1_q != '1) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

    // The sp_fifo presents read data in the cycle c_valid is high; hold it afterwards.
    assign c_data        = c_valid_q ? fifo_dout : c_data_hold_q;
    assign p0_ready      = gnt0;
    assign p1_ready      = gnt1;
    assign c_ack         = ack;
    assign c_valid       = c_valid_q;
    assign fifo_wr_en    = fifo_wr_en_q;
    assign fifo_din      = fifo_din_q;
    assign fifo_rd_en    = fifo_rd_en_q;
    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign underflow_err = underflow_q;

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Scope: two-producer round-robin write arbiter plus single-consumer read sequencer for one 16-deep x 8-bit sp_fifo (ports clk, rst_n, wr_en, din, rd_en, dout; 1-cycle read latency; no full/empty flags). This controller owns occupancy tracking.

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entry count; count width is $clog2(DEPTH)+1.
REQ-002 SHALL provide clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL provide rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide p0_valid  input  1  producer 0 has data.
REQ-005 SHALL provide p0_data  input  8  producer 0 byte.
REQ-006 SHALL provide p0_ready  output  1  producer 0 granted this cycle (combinational).
REQ-007 SHALL provide p1_valid, p1_data, p1_ready with the same directions, widths and meaning for producer 1.
REQ-008 SHALL provide c_req  input  1  consumer requests one byte.
REQ-009 SHALL provide c_ack  output  1  consumer request accepted this cycle (combinational).
REQ-010 SHALL provide c_valid  output  1  c_data valid, registered.
REQ-011 SHALL provide c_data  output  8  byte returned to consumer, sampled from fifo_dout.
REQ-012 SHALL provide fifo_wr_en, fifo_din[7:0], fifo_rd_en  outputs  registered drive of sp_fifo wr_en/din/rd_en.
REQ-013 SHALL provide fifo_dout  input  8  sp_fifo dout.
REQ-014 SHALL provide count  output  5  current occupancy 0..16; full/empty  outputs  1  count==16 / count==0.
REQ-015 SHALL provide underflow_err  output  1  one-cycle pulse, c_req while empty.

Function
REQ-016 Write transfer = pN_valid & pN_ready; at most one producer granted per cycle.
REQ-017 pN_ready SHALL be 0 whenever full=1, regardless of same-cycle consumer acceptance (no write-through-full).
REQ-018 Both valid and not full: grant the producer not granted last (rr pointer); one valid: grant it; pointer updates only on a transfer.
REQ-019 On a write transfer, next cycle fifo_wr_en=1 and fifo_din=granted data; otherwise fifo_wr_en=0, fifo_din holds.
REQ-020 c_ack = c_req & ~empty; a same-cycle write does not make an empty FIFO readable (no bypass).
REQ-021 On c_ack, next cycle fifo_rd_en=1; the cycle after, c_valid=1 and c_data=fifo_dout; back-to-back c_ack gives one c_valid per cycle, 2-cycle latency.
REQ-022 count: +1 on write transfer only, -1 on c_ack only, unchanged on both or neither; never wraps below 0 or above 16.
REQ-023 underflow_err SHALL pulse for each cycle with c_req=1 and empty=1; count unchanged.

Reset
REQ-024 rst_n low asynchronously clears count=0, rr pointer to "producer 1 last" (producer 0 wins first tie), fifo_wr_en=0, fifo_din=0, fifo_rd_en=0, c_valid=0, c_data=0, underflow_err=0, stat counters=0.
REQ-025 Reset mid-operation SHALL discard in-flight c_valid and the rr history; ready/ack SHALL be 0 while rst_n=0.

Configuration
REQ-026 Macro FIFO_ARB_STATS_EN: when defined, adds outputs grant_cnt0[15:0], grant_cnt1[15:0], incremented per write transfer of that producer, saturating at 16'hFFFF, cleared by reset.
REQ-027 Without FIFO_ARB_STATS_EN those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 Both producers valid continuously, data 0x00.. and 0x80.., no reads -> grants alternate P0,P1,...; 16 writes; full=1 at count=16; both ready=0 afterwards.
REQ-029 From full, c_req held 16 cycles -> c_data order 0x00,0x80,0x01,0x81,...; c_valid 2 cycles after each c_ack; empty=1 after the 16th ack.
REQ-030 count=5, write transfer and c_ack same cycle -> count stays 5; fifo_wr_en and fifo_rd_en both 1 next cycle.
REQ-031 Empty, c_req=1 and p0 writes 0x3C same cycle -> c_ack=0, underflow_err=1, count=1; next-cycle c_req acked, c_data=0x3C.
REQ-032 count=16, c_ack with p0_valid same cycle -> p0_ready=0, count=15; p0 accepted following cycle.
REQ-033 rst_n asserted while c_valid pipeline busy -> all outputs at reset values immediately; with FIFO_ARB_STATS_EN, grant_cnt0/1 read 0.
